// File: rtl/stopwatch_display_if.sv
// Signal bundle between the stopwatch core (master) and the 7-segment display driver (slave).
// Q[4k+1] is the MSB of BCD digit k (digit 0 = seconds units).
interface stopwatch_display_if;
  logic [1:16] Q;
  logic        ON_OFF;
  logic        LAP;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;
  logic        ERR;

  modport master (output Q, ON_OFF, LAP, input SEG, AN, DP, ERR);
  modport slave  (input Q, ON_OFF, LAP, output SEG, AN, DP, ERR);
endinterface

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode 7-segment driver: scan, BCD decode, leading-zero blanking,
// blinking colon, lap freeze and a sticky non-BCD error flag.
module stopwatch_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 50,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic               clk,
  input  logic               RESET,
  stopwatch_display_if.slave bus
);
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          ph;
  logic          lap_q;
  logic          frz;
  logic [15:0]   disp;
  logic          err;

  logic [15:0]   qn;
  logic          q_bad;
  logic          wrap;
  logic          frame_end;
  logic          cap;
  logic [3:0]    d;
  logic [6:0]    seg_dec;

  // Repack the ascending Q[1:16] bus so digit k sits in qn[4k+3:4k].
  always_comb begin
    qn    = '0;
    q_bad = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      qn[4*k +: 4] = bus.Q[4*k+1 +: 4];
      if (bus.Q[4*k+1 +: 4] > 4'd9) q_bad = 1'b1;
    end
  end

  always_comb begin
    wrap      = (cnt == CW'(SCAN_DIV - 1));
    frame_end = wrap && (idx == 2'd3);
    cap       = (cnt == '0) && (idx == 2'd0) && !frz;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt   <= '0;
      idx   <= '0;
      fcnt  <= '0;
      ph    <= 1'b1;
      lap_q <= 1'b0;
      frz   <= 1'b0;
      disp  <= '0;
      err   <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;

      // Capture decision uses frz before any toggle on this same edge.
      if (cap) begin
        disp <= qn;
        if (q_bad) err <= 1'b1;
      end

      lap_q <= bus.LAP;
      if (bus.LAP && !lap_q) frz <= ~frz;

      if (!bus.ON_OFF) begin
        ph   <= 1'b1;
        fcnt <= '0;
      end else if (frame_end) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt <= '0;
          ph   <= ~ph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    d = disp[4*idx +: 4];
    unique case (d)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end

  always_comb begin
    bus.SEG = seg_dec;
    bus.AN  = '1;
    bus.DP  = 1'b1;
    bus.ERR = err;
    if (RESET) begin
      bus.SEG = '1;
    end else begin
      if (BLANK_LZ && idx == 2'd3 && d == 4'd0) bus.SEG = '1;
      // Slot's first cycle keeps all anodes off to avoid ghosting.
      if (cnt != '0) bus.AN = ~(4'b0001 << idx);
      if (idx == 2'd2 && cnt != '0 && ph) bus.DP = 1'b0;
    end
  end
endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized and directed bench for stopwatch_display; two instances differ only in BLANK_LZ
// and are both compared every cycle against a cycle-count based reference model.
module tb_stopwatch_display;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] q_h = 16'h0000;
  logic        on_off = 1'b0;
  logic        lap = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  stopwatch_display_if sw1 ();
  stopwatch_display_if sw0 ();

  function automatic logic [1:16] to_q(input logic [15:0] h);
    logic [1:16] r;
    for (int k = 0; k < 4; k++) r[4*k+1 +: 4] = h[4*k +: 4];
    return r;
  endfunction

  assign sw1.Q      = to_q(q_h);
  assign sw0.Q      = to_q(q_h);
  assign sw1.ON_OFF = on_off;
  assign sw0.ON_OFF = on_off;
  assign sw1.LAP    = lap;
  assign sw0.LAP    = lap;

  stopwatch_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .RESET(rst), .bus(sw1)
  );
  stopwatch_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .RESET(rst), .bus(sw0)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is derived from cycles since reset.
  logic [6:0] seg_tab [16];
  int   t = 0;
  int   dig [4] = '{0, 0, 0, 0};
  bit   frz_m = 0;
  bit   lapq_m = 0;
  bit   ph_m = 1;
  bit   err_m = 0;
  int   nfr = 0;

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
  endtask

  task automatic compare_one(input string nm, input bit blank,
                             input logic [6:0] seg, input logic [3:0] an,
                             input logic dp, input logic err);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    int         c, ix;
    if (rst) begin
      e_seg = 7'h7f; e_an = 4'hf; e_dp = 1'b1;
    end else begin
      c  = t % SD;
      ix = (t / SD) % 4;
      e_seg = (blank && ix == 3 && dig[ix] == 0) ? 7'h7f : seg_tab[dig[ix]];
      e_an  = (c == 0) ? 4'hf : 4'hf & ~(4'h1 << ix);
      e_dp  = (ix == 2 && c != 0 && ph_m) ? 1'b0 : 1'b1;
    end
    check({nm, ".seg"}, 32'(seg), 32'(e_seg));
    check({nm, ".an"},  32'(an),  32'(e_an));
    check({nm, ".dp"},  32'(dp),  32'(e_dp));
    check({nm, ".err"}, 32'(err), 32'(err_m));
  endtask

  task automatic model_edge();
    if (rst) begin
      t = 0; dig = '{0, 0, 0, 0};
      frz_m = 0; lapq_m = 0; ph_m = 1; err_m = 0; nfr = 0;
    end else begin
      if (t % FR == 0 && !frz_m) begin
        for (int k = 0; k < 4; k++) begin
          dig[k] = int'(q_h[4*k +: 4]);
          if (dig[k] > 9) err_m = 1;
        end
      end
      if (!on_off) begin
        nfr = 0; ph_m = 1;
      end else if (t % FR == FR - 1) begin
        nfr++;
        ph_m = ((nfr / BF) % 2) == 0;
      end
      if (lap && !lapq_m) frz_m = !frz_m;
      lapq_m = lap;
      t++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_one("lz1", 1'b1, sw1.SEG, sw1.AN, sw1.DP, sw1.ERR);
    compare_one("lz0", 1'b0, sw0.SEG, sw0.AN, sw0.DP, sw0.ERR);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FR && (t % FR) != ph; i++) step();
  endtask

  task automatic lap_pulse();
    lap = 1'b1; run(3);
    lap = 1'b0; run(1);
  endtask

  function automatic logic [15:0] rand_q();
    logic [15:0] r;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    run(2);
    rst = 1'b0;
    // Scan order and decode
    q_h = 16'h1234; run(2 * FR);
    // Capture boundary: change during slot 1
    run_to_phase(SD + 1);
    q_h = 16'h5678; run(2 * FR);
    // Leading zero, both blanking settings
    q_h = 16'h0059; run(2 * FR);
    // Lap freeze / unfreeze
    q_h = 16'h0001; run(FR);
    lap_pulse();
    q_h = 16'h0002; run(3 * FR);
    lap_pulse();
    run(2 * FR);
    // Colon blink, then steady
    on_off = 1'b1; run(10 * FR);
    on_off = 1'b0; run(3 * FR);
    // Non-BCD capture, sticky error, mid-frame reset
    q_h = 16'h000C; run(2 * FR);
    q_h = 16'h1234; run(2 * FR);
    run_to_phase(SD + 2);
    rst = 1'b1; run(1);
    rst = 1'b0; run(2 * FR);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) q_h = rand_q();
      if ($urandom_range(0, 99) == 0) on_off = ~on_off;
      if ($urandom_range(0, 59) == 0) lap = ~lap;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    run(FR);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
